adder_tree_acc: RTL and testbench
=================================

ADDER_TREE_ACC -- requirements
Module: adder_tree_acc

Interface
REQ-001 SHALL have parameter INP_WIDTH, default 8: signed width of each input lane.
REQ-002 SHALL have parameter OUT_WIDTH, default 16: signed width of the accumulator and result.
REQ-003 SHALL have parameter NUM_IN, default 4: lane count, a power of two, 2..64.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic rising-edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1: in_data/in_last qualify this cycle.
REQ-007 SHALL have port in_data, input, NUM_IN*INP_WIDTH: packed signed lanes; lane k at bits [k*INP_WIDTH +: INP_WIDTH].
REQ-008 SHALL have port in_last, input, 1: final beat of an accumulation group.
REQ-009 SHALL have port acc_clr, input, 1: discard any partial group.
REQ-010 SHALL have port out_valid, output, 1: one-cycle pulse, result valid.
REQ-011 SHALL have port out_data, output, OUT_WIDTH: signed group sum.
REQ-012 SHALL have port out_ovf, output, 1: overflow occurred in the reported group.

Function
REQ-013 SHALL sum all NUM_IN lanes per valid beat in a registered binary tree of L = log2(NUM_IN) stages; stage s width = INP_WIDTH+s, so the tree never overflows.
REQ-014 SHALL carry valid and last through the tree alongside data; a beat presented in cycle t reaches the accumulator in cycle t+L.
REQ-015 SHALL sign-extend the tree sum to OUT_WIDTH, or truncate it to OUT_WIDTH when INP_WIDTH+L > OUT_WIDTH, setting the group overflow flag if the value is lost.
REQ-016 SHALL keep an accumulator FSM with states IDLE (no partial group) and ACC (partial group held).
REQ-017 SHALL, on a tree-output beat in IDLE, load acc = beat sum; in ACC, acc = acc + beat sum.
REQ-018 SHALL, on a beat with last, register acc+beat (or the beat alone from IDLE) into out_data, pulse out_valid the next cycle, and return to IDLE; total latency in_valid&in_last to out_valid = L+1 cycles.
REQ-019 SHALL treat a single beat with last in IDLE as a complete one-beat group.
REQ-020 SHALL accept one beat per cycle with no stall; there is no backpressure.
REQ-021 SHALL detect signed overflow of each accumulator add (operand signs equal, result sign differs) and OR it into a sticky flag reported on out_ovf with the group, then cleared.
REQ-022 SHALL, on acc_clr, flush the tree pipeline and accumulator, drop the partial group, clear the flag, go to IDLE, and emit no out_valid for the dropped group; beats with in_valid in the acc_clr cycle are also dropped.
REQ-023 SHALL hold out_data and out_ovf between pulses.

Reset
REQ-024 SHALL, while rst_n = 0 at a clk edge, clear all pipeline valids, the accumulator, and the flag, and enter IDLE; out_valid = 0, out_data = 0, out_ovf = 0.
REQ-025 SHALL abandon any in-flight group on reset; the first beat after rst_n rises starts a new group.

Configuration
REQ-026 SHALL honour macro ADDER_TREE_SAT_EN: when defined, every accumulator add and the REQ-015 narrowing clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; when undefined, they wrap two's-complement; out_ovf reports the event in both builds.

Structure
REQ-027 SHALL place the saturation bounds function, the log2 constant function, and the FSM state encoding in shared package nn_arith_pkg.
REQ-028 SHALL instantiate one sub-module, adder_tree_stage: one registered pairwise-add level, parameterised by width and pair count, generated L times.

Verification
All cases use NUM_IN=4, INP_WIDTH=8, OUT_WIDTH=16, L=2.
REQ-029 SHALL check single beat: lanes {1,2,3,4}, in_last=1 -> out_valid exactly 3 cycles later, out_data=10, out_ovf=0.
REQ-030 SHALL check group: three back-to-back beats {-128 x4}, {127 x4}, {-1 x4}, last on beat 3 -> one pulse, out_data=-8.
REQ-031 SHALL check overflow: 70 beats {127 x4}, last on beat 70 (true sum 35560) -> SAT build: out_data=32767, out_ovf=1; wrap build: out_data=-29976, out_ovf=1; next group out_ovf=0.
REQ-032 SHALL check clear: two beats, then acc_clr mid-group, then {5 x4} with last -> the only pulse carries 20.
REQ-033 SHALL check reset: rst_n=0 one cycle while beats are in the tree -> no pulse; outputs 0; a following one-beat group {1,1,1,1} yields 4.
REQ-034 SHALL check boundary: last beats on consecutive cycles {1 x4}, {2 x4} -> pulses on consecutive cycles with values 4 and 8.

Source files
------------

// File: rtl/nn_arith_pkg.sv
// Shared arithmetic helpers for the adder tree accumulator: accumulator FSM
// state encoding, a constant log2 and the saturation bound generator.
package nn_arith_pkg;

  // Accumulator FSM states: IDLE holds no partial group, ACC holds one.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } acc_state_e;

  // Ceiling log2, used at elaboration to size the tree depth.
  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  // Two's-complement bound for a w-bit signed value, returned in 64 bits.
  // neg=1 gives -2^(w-1), neg=0 gives 2^(w-1)-1; callers keep the low w bits.
  function automatic logic [63:0] sat_bound(input int w, input logic neg);
    logic [63:0] one;
    one = 64'd1;
    if (neg) return ~((one << (w - 1)) - one);
    return (one << (w - 1)) - one;
  endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One registered level of the adder tree: PAIRS independent pairwise adds of
// W-bit signed lanes into (W+1)-bit lanes, so the level can never overflow.
// Valid and last travel with the data; flush drops whatever is in the level.
module adder_tree_stage #(
  parameter int W     = 8,
  parameter int PAIRS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic [2*PAIRS*W-1:0]   in_data,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [PAIRS*(W+1)-1:0] out_data
);

  logic [PAIRS*(W+1)-1:0] sum_c;

  // Sign-extend each lane of a pair by one bit and add.
  always_comb begin
    sum_c = '0;
    for (int j = 0; j < PAIRS; j++) begin
      sum_c[j*(W+1) +: W+1] =
        {in_data[2*j*W + W - 1], in_data[2*j*W +: W]} +
        {in_data[(2*j+1)*W + W - 1], in_data[(2*j+1)*W +: W]};
    end
  end

  // Level register; reset and flush both empty it.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      out_last  <= in_last;
      out_data  <= sum_c;
    end
  end

endmodule

// File: rtl/adder_tree_acc.sv
// Adder tree accumulator: sums NUM_IN signed lanes per beat through a
// registered binary tree, then accumulates beats into groups closed by
// in_last. Result latency from a last beat to out_valid is log2(NUM_IN)+1.
// Optional build macro ADDER_TREE_SAT_EN: saturate instead of wrap.
//
// Handshake: in_valid qualifies in_data/in_last for the cycle it is high;
// there is no ready, every valid beat is accepted. out_valid is a one-cycle
// pulse with no ready; out_data/out_ovf hold their value between pulses.
module adder_tree_acc
  import nn_arith_pkg::*;
#(
  parameter int INP_WIDTH = 8,
  parameter int OUT_WIDTH = 16,
  parameter int NUM_IN    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [NUM_IN*INP_WIDTH-1:0] in_data,
  input  logic                        in_last,
  input  logic                        acc_clr,
  output logic                        out_valid,
  output logic [OUT_WIDTH-1:0]        out_data,
  output logic                        out_ovf,
  output acc_state_e                  dbg_state
);

  localparam int L  = clog2_f(NUM_IN);
  localparam int TW = INP_WIDTH + L;
  localparam int M  = OUT_WIDTH - 1;

  // Offset of tree level s inside the flat level bus; level s holds
  // NUM_IN>>s lanes of INP_WIDTH+s bits, level 0 being the raw input.
  function automatic int lvl_off(input int s);
    int off;
    off = 0;
    for (int i = 0; i < s; i++) off = off + (NUM_IN >> i) * (INP_WIDTH + i);
    return off;
  endfunction

  localparam int BUS_W   = lvl_off(L + 1);
  localparam int TREE_AT = lvl_off(L);

`ifdef ADDER_TREE_SAT_EN
  localparam logic [63:0]          BOUND_MAX = sat_bound(OUT_WIDTH, 1'b0);
  localparam logic [63:0]          BOUND_MIN = sat_bound(OUT_WIDTH, 1'b1);
  localparam logic [OUT_WIDTH-1:0] SAT_MAX   = BOUND_MAX[OUT_WIDTH-1:0];
  localparam logic [OUT_WIDTH-1:0] SAT_MIN   = BOUND_MIN[OUT_WIDTH-1:0];
`endif

  logic [BUS_W-1:0] lvl_bus;
  logic [L:0]       lvl_valid;
  logic [L:0]       lvl_last;

  assign lvl_bus[NUM_IN*INP_WIDTH-1:0] = in_data;
  assign lvl_valid[0]                  = in_valid;
  assign lvl_last[0]                   = in_last;

  // acc_clr flushes every level, including the beat presented with it.
  genvar s;
  for (s = 0; s < L; s++) begin : g_lvl
    localparam int W       = INP_WIDTH + s;
    localparam int P       = NUM_IN >> (s + 1);
    localparam int OFF_IN  = lvl_off(s);
    localparam int OFF_OUT = lvl_off(s + 1);
    adder_tree_stage #(
      .W     (W),
      .PAIRS (P)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (acc_clr),
      .in_valid  (lvl_valid[s]),
      .in_last   (lvl_last[s]),
      .in_data   (lvl_bus[OFF_IN +: 2*P*W]),
      .out_valid (lvl_valid[s+1]),
      .out_last  (lvl_last[s+1]),
      .out_data  (lvl_bus[OFF_OUT +: P*(W+1)])
    );
  end

  logic                 tree_valid;
  logic                 tree_last;
  logic [TW-1:0]        tree_sum;
  logic [OUT_WIDTH-1:0] beat;
  logic                 narrow_lost;

  assign tree_valid = lvl_valid[L];
  assign tree_last  = lvl_last[L];
  assign tree_sum   = lvl_bus[TREE_AT +: TW];

  // Bring the tree sum to accumulator width; only the truncating case can
  // lose information, detected by the dropped top bits not all matching sign.
  if (TW > OUT_WIDTH) begin : g_trunc
    logic [TW-OUT_WIDTH:0] top;
    assign top         = tree_sum[TW-1:OUT_WIDTH-1];
    assign narrow_lost = !((&top) || !(|top));
`ifdef ADDER_TREE_SAT_EN
    assign beat = narrow_lost ? (tree_sum[TW-1] ? SAT_MIN : SAT_MAX)
                              : tree_sum[OUT_WIDTH-1:0];
`else
    assign beat = tree_sum[OUT_WIDTH-1:0];
`endif
  end else if (TW == OUT_WIDTH) begin : g_same
    assign narrow_lost = 1'b0;
    assign beat        = tree_sum;
  end else begin : g_sext
    assign narrow_lost = 1'b0;
    assign beat        = {{(OUT_WIDTH-TW){tree_sum[TW-1]}}, tree_sum};
  end

  acc_state_e           state_q, state_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic                 flag_q, flag_d;
  logic [OUT_WIDTH-1:0] base;
  logic [OUT_WIDTH-1:0] sum_w;
  logic [OUT_WIDTH-1:0] add_res;
  logic                 add_ovf;
  logic                 beat_ovf;
  logic                 emit;

  assign dbg_state = state_q;

  // Accumulator datapath and FSM next state. From IDLE the beat is added to
  // zero, so the same adder covers both load and accumulate.
  always_comb begin
    base     = (state_q == ST_ACC) ? acc_q : '0;
    sum_w    = base + beat;
    add_ovf  = (base[M] == beat[M]) && (sum_w[M] != base[M]);
`ifdef ADDER_TREE_SAT_EN
    add_res  = add_ovf ? (base[M] ? SAT_MIN : SAT_MAX) : sum_w;
`else
    add_res  = sum_w;
`endif
    beat_ovf = narrow_lost | add_ovf;
    state_d  = state_q;
    acc_d    = acc_q;
    flag_d   = flag_q;
    emit     = 1'b0;
    if (acc_clr) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      flag_d  = 1'b0;
    end else if (tree_valid) begin
      if (tree_last) begin
        emit    = 1'b1;
        state_d = ST_IDLE;
        acc_d   = '0;
        flag_d  = 1'b0;
      end else begin
        state_d = ST_ACC;
        acc_d   = add_res;
        flag_d  = flag_q | beat_ovf;
      end
    end
  end

  // FSM state, running sum and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      flag_q  <= flag_d;
    end
  end

  // Result register: pulse on group close, hold data and flag otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= emit;
      if (emit) begin
        out_data <= add_res;
        out_ovf  <= flag_q | beat_ovf;
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_acc.sv
// Bench for adder_tree_acc with NUM_IN=4, INP_WIDTH=8, OUT_WIDTH=16 (L=2).
module tb_adder_tree_acc;
  import nn_arith_pkg::*;

  localparam int EXP_W = 49;  // {cycle[31:0], ovf, data[15:0]}

`ifdef ADDER_TREE_SAT_EN
  localparam int OVF_DATA = 32767;
`else
  localparam int OVF_DATA = -29976;
`endif

  logic               clk      = 1'b0;
  logic               rst_n    = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_last  = 1'b0;
  logic               acc_clr  = 1'b0;
  logic [31:0]        in_data  = '0;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               out_ovf;
  acc_state_e         dbg_state;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  typedef struct {
    logic [31:0] data;
    int          exp;
  } vec_t;

  adder_tree_acc #(
    .INP_WIDTH (8),
    .OUT_WIDTH (16),
    .NUM_IN    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required $finish before it");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input integer act, input integer exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // Driver: one beat, sampled at the next rising edge. A pulse is expected
  // three rising edges after that beat was applied.
  task automatic send(input logic [31:0] d, input logic last, input logic clr,
                      input logic want, input int exp_data, input logic exp_ovf);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    acc_clr  = clr;
    if (want) exp_q.push_back({32'(cyc + 3), exp_ovf, 16'(exp_data)});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      acc_clr  = 1'b0;
      in_data  = '0;
    end
  endtask

  // Scoreboard: every pulse must match the head of exp_q in cycle and value
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (exp_q.size() != 0 && cyc > int'(exp_q[0][48:17])) begin
      checks++;
      errors++;
      $display("FAIL pulse_missing: no out_valid by cycle %0d, required data %0d",
               exp_q[0][48:17], $signed(exp_q[0][15:0]));
      void'(exp_q.pop_front());
    end
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: out_valid at cycle %0d data %0d, required no pulse",
                 cyc, out_data);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_cycle", cyc, e[48:17]);
        chk("out_data", out_data, $signed(e[15:0]));
        chk("out_ovf", out_ovf, e[16]);
      end
    end
  end

  initial begin
    vec_t tbl[6];
    tbl[0] = '{pack4(1, 2, 3, 4), 10};
    tbl[1] = '{pack4(-128, -128, -128, -128), -512};
    tbl[2] = '{pack4(127, 127, 127, 127), 508};
    tbl[3] = '{pack4(0, 0, 0, 0), 0};
    tbl[4] = '{pack4(-1, 2, -3, 4), 2};
    tbl[5] = '{pack4(127, -128, 5, -6), -2};

    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_ovf", out_ovf, 0);
    chk("reset_state", dbg_state, ST_IDLE);

    // One-beat groups, back to back
    for (int i = 0; i < 6; i++) send(tbl[i].data, 1'b1, 1'b0, 1'b1, tbl[i].exp, 1'b0);
    idle(5);
    chk("hold_data", out_data, tbl[5].exp);
    chk("hold_ovf", out_ovf, 0);

    // Three-beat group
    send(pack4(-128, -128, -128, -128), 1'b0, 1'b0, 1'b0, 0, 1'b0);
    send(pack4(127, 127, 127, 127), 1'b0, 1'b0, 1'b0, 0, 1'b0);
    send(pack4(-1, -1, -1, -1), 1'b1, 1'b0, 1'b1, -8, 1'b0);
    idle(5);

    // Overflowing 70-beat group, then a clean group
    for (int i = 0; i < 70; i++)
      send(pack4(127, 127, 127, 127), (i == 69), 1'b0, (i == 69), OVF_DATA, 1'b1);
    idle(5);
    chk("ovf_hold", out_ovf, 1);
    send(pack4(1, 2, 3, 4), 1'b1, 1'b0, 1'b1, 10, 1'b0);
    idle(5);

    // Clear while beats are in the tree; the beat in the clear cycle is dropped
    send(pack4(3, 3, 3, 3), 1'b0, 1'b0, 1'b0, 0, 1'b0);
    send(pack4(7, 7, 7, 7), 1'b0, 1'b0, 1'b0, 0, 1'b0);
    send(pack4(9, 9, 9, 9), 1'b1, 1'b1, 1'b0, 0, 1'b0);
    send(pack4(5, 5, 5, 5), 1'b1, 1'b0, 1'b1, 20, 1'b0);
    idle(6);

    // Clear while the partial group sits in the accumulator
    send(pack4(3, 3, 3, 3), 1'b0, 1'b0, 1'b0, 0, 1'b0);
    idle(4);
    chk("state_acc", dbg_state, ST_ACC);
    send(pack4(0, 0, 0, 0), 1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle(1);
    chk("state_after_clr", dbg_state, ST_IDLE);
    send(pack4(5, 5, 5, 5), 1'b1, 1'b0, 1'b1, 20, 1'b0);
    idle(5);

    // Reset pulse with beats in flight
    send(pack4(2, 2, 2, 2), 1'b0, 1'b0, 1'b0, 0, 1'b0);
    send(pack4(6, 6, 6, 6), 1'b1, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    send(pack4(1, 1, 1, 1), 1'b1, 1'b0, 1'b1, 4, 1'b0);
    idle(5);

    // Last beats on consecutive cycles
    send(pack4(1, 1, 1, 1), 1'b1, 1'b0, 1'b1, 4, 1'b0);
    send(pack4(2, 2, 2, 2), 1'b1, 1'b0, 1'b1, 8, 1'b0);
    idle(6);

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
